// File: rtl/br_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup of the fetch PC,
// trained from EX/MEM on taken branches and JALs, with saturating perf counters.
module br_target_buffer #(
  parameter int unsigned IDX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [6:0]  opcode,
  input  logic        predict_dir,
  input  logic [31:0] ex_mem_pc,
  input  logic [6:0]  ex_mem_opcode,
  input  logic        ex_mem_br_en,
  input  logic [31:0] ex_mem_target,
  output logic        btb_hit,
  output logic        predict_taken,
  output logic [31:0] predict_pc,
  output logic [31:0] lookup_count,
  output logic [31:0] hit_count
);

  localparam int unsigned DEPTH = 1 << IDX;
  localparam int unsigned TAG_W = 32 - IDX - 2;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             is_ctrl;
  logic             do_update;
  logic [31:0]      lookup_cnt;
  logic [31:0]      hit_cnt;
  logic             unused_pc_bits;

  assign rd_idx = pc[IDX+1:2];
  assign rd_tag = pc[31:IDX+2];
  assign wr_idx = ex_mem_pc[IDX+1:2];
  assign wr_tag = ex_mem_pc[31:IDX+2];

  // Byte offset within the instruction word plays no part in indexing or tagging.
  assign unused_pc_bits = ^{pc[1:0], ex_mem_pc[1:0]};

  assign is_ctrl   = (opcode == OP_BRANCH) || (opcode == OP_JAL);
  assign do_update = !stall &&
                     (((ex_mem_opcode == OP_BRANCH) && ex_mem_br_en) ||
                      (ex_mem_opcode == OP_JAL));

  always_comb begin
    btb_hit       = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    predict_taken = 1'b0;
    case (opcode)
      OP_BRANCH: predict_taken = btb_hit && predict_dir;
      OP_JAL:    predict_taken = btb_hit;
      default:   predict_taken = 1'b0;
    endcase
    predict_pc = predict_taken ? target_mem[rd_idx] : pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (do_update) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage is left unreset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!rst && do_update) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= ex_mem_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt <= '0;
      hit_cnt    <= '0;
    end else if (!stall && is_ctrl) begin
      if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + 32'd1;
      if (predict_taken && (hit_cnt != '1)) hit_cnt <= hit_cnt + 32'd1;
    end
  end

  assign lookup_count = lookup_cnt;
  assign hit_count    = hit_cnt;

endmodule

// File: tb/tb_br_target_buffer.sv
// Scoreboard bench for br_target_buffer: a driver pushes expected lookups from a
// PC-keyed reference model; a monitor pops and compares against the DUT outputs.
module tb_br_target_buffer;

  localparam int unsigned IDX   = 5;
  localparam int unsigned DEPTH = 1 << IDX;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst, stall, predict_dir, ex_mem_br_en;
  logic [31:0] pc, ex_mem_pc, ex_mem_target;
  logic [6:0]  opcode, ex_mem_opcode;
  logic        btb_hit, predict_taken;
  logic [31:0] predict_pc, lookup_count, hit_count;

  br_target_buffer #(.IDX(IDX)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .opcode(opcode),
    .predict_dir(predict_dir), .ex_mem_pc(ex_mem_pc), .ex_mem_opcode(ex_mem_opcode),
    .ex_mem_br_en(ex_mem_br_en), .ex_mem_target(ex_mem_target),
    .btb_hit(btb_hit), .predict_taken(predict_taken), .predict_pc(predict_pc),
    .lookup_count(lookup_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        hit;
    logic        taken;
    logic [31:0] ppc;
    logic [31:0] lc;
    logic [31:0] hc;
    bit          dir;
    logic        dhit;
    logic [31:0] dppc;
  } exp_t;

  exp_t queue_exp[$];
  event issued;
  int checks   = 0;
  int failures = 0;
  bit stim_done = 0;

  // Reference model: each slot remembers the full PC that trained it.
  bit          m_valid [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  logic [31:0] m_lc, m_hc;

  function automatic int unsigned slot(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  task automatic check(input string nm, input string field,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [31:0] p,
                      input logic [6:0] op, input logic pd,
                      input logic [31:0] xpc, input logic [6:0] xop,
                      input logic xbr, input logic [31:0] xtgt,
                      input bit dir, input logic dhit, input logic [31:0] dppc,
                      input string nm);
    exp_t e;
    int unsigned i;
    bit hit, tk;
    @(negedge clk);
    rst = r; stall = s; pc = p; opcode = op; predict_dir = pd;
    ex_mem_pc = xpc; ex_mem_opcode = xop; ex_mem_br_en = xbr; ex_mem_target = xtgt;
    i   = slot(p);
    hit = m_valid[i] && ((m_pc[i] >> (IDX + 2)) == (p >> (IDX + 2)));
    tk  = (op == BR) ? (hit && pd) : (op == JAL) ? hit : 1'b0;
    e.nm = nm; e.hit = hit; e.taken = tk;
    e.ppc = tk ? m_tgt[i] : p + 32'd4;
    e.lc = m_lc; e.hc = m_hc;
    e.dir = dir; e.dhit = dhit; e.dppc = dppc;
    queue_exp.push_back(e);
    ->issued;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
      m_lc = '0; m_hc = '0;
    end else if (!s) begin
      if ((op == BR) || (op == JAL)) begin
        if (m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
        if (tk && (m_hc != 32'hFFFF_FFFF)) m_hc = m_hc + 1;
      end
      if (((xop == BR) && xbr) || (xop == JAL)) begin
        m_valid[slot(xpc)] = 1;
        m_pc[slot(xpc)]    = xpc;
        m_tgt[slot(xpc)]   = xtgt;
      end
    end
  endtask

  task automatic look(input logic [31:0] p, input logic [6:0] op, input logic pd,
                      input logic dhit, input logic [31:0] dppc, input string nm);
    step(0, 0, p, op, pd, 32'h0, ALU, 0, 32'h0, 1, dhit, dppc, nm);
  endtask

  task automatic train(input logic [31:0] xpc, input logic [6:0] xop,
                       input logic xbr, input logic [31:0] xtgt);
    step(0, 0, 32'h0000_1000, ALU, 0, xpc, xop, xbr, xtgt, 0, 0, 0, "train");
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, DEPTH - 1) << 2)
        | $urandom_range(0, 3);
    if ($urandom_range(0, 31) == 0) a = 32'hFFFF_FFFC;
    return a;
  endfunction

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [4];
    ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ALU;
    return ops[$urandom_range(0, 3)];
  endfunction

  task automatic rand_step(input string nm);
    step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, rand_pc(), rand_op(),
         1'($urandom_range(0, 1)), rand_pc(), rand_op(), 1'($urandom_range(0, 1)),
         $urandom, 0, 0, 0, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(issued);
      #1;
      if (queue_exp.size() == 0) begin
        check("monitor", "queue_size", 0, 1);
      end else begin
        e = queue_exp.pop_front();
        check(e.nm, "btb_hit", btb_hit, e.hit);
        check(e.nm, "predict_taken", predict_taken, e.taken);
        check(e.nm, "predict_pc", predict_pc, e.ppc);
        check(e.nm, "lookup_count", lookup_count, e.lc);
        check(e.nm, "hit_count", hit_count, e.hc);
        if (e.dir) begin
          check(e.nm, "dir_hit", btb_hit, e.dhit);
          check(e.nm, "dir_pc", predict_pc, e.dppc);
        end
      end
    end
  end

  initial begin : driver
    rst = 1; stall = 0; pc = '0; opcode = ALU; predict_dir = 0;
    ex_mem_pc = '0; ex_mem_opcode = ALU; ex_mem_br_en = 0; ex_mem_target = '0;
    m_lc = '0; m_hc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m_valid[k] = 0; m_pc[k] = '0; m_tgt[k] = '0;
    end
    for (int k = 0; k < 5; k++)
      step(1, 0, 32'h0, ALU, 0, 32'h40, BR, 1, 32'h999, 0, 0, 0, "reset_hold");
    look(32'h40, BR, 1, 0, 32'h44, "reset_lookup");

    train(32'h40, BR, 1, 32'h100);
    look(32'h40, BR, 1, 1, 32'h100, "hit_taken");
    look(32'h40, BR, 0, 1, 32'h44, "hit_dir_nt");

    train(32'hC0, JAL, 0, 32'h200);
    look(32'h40, BR, 1, 0, 32'h44, "alias_victim");
    look(32'hC0, JAL, 0, 1, 32'h200, "alias_jal");

    train(32'hC0, BR, 0, 32'h999);
    look(32'hC0, JAL, 0, 1, 32'h200, "not_taken_keep");
    step(0, 1, 32'h140, JAL, 1, 32'h140, JAL, 1, 32'h300, 1, 0, 32'h144, "stalled");
    look(32'h140, JAL, 1, 0, 32'h144, "stall_no_write");
    look(32'hC0, JAL, 0, 1, 32'h200, "stall_keep");

    step(0, 0, 32'h80, BR, 1, 32'h80, BR, 1, 32'h400, 1, 0, 32'h84, "same_cycle");
    look(32'h80, BR, 1, 1, 32'h400, "after_write");
    look(32'h80, JALR, 1, 1, 32'h84, "jalr_no_redirect");
    look(32'hFFFF_FFFC, ALU, 0, 0, 32'h0, "pc_wrap");

    step(1, 0, 32'h0, ALU, 0, 32'h80, JAL, 1, 32'h500, 0, 0, 0, "mid_reset");
    look(32'h80, BR, 1, 0, 32'h84, "post_reset");

    for (int n = 0; n < 2000; n++) rand_step("random");

    #1;
    force dut.lookup_cnt = 32'hFFFF_FFFF;
    force dut.hit_cnt    = 32'hFFFF_FFFF;
    #1;
    release dut.lookup_cnt;
    release dut.hit_cnt;
    m_lc = 32'hFFFF_FFFF;
    m_hc = 32'hFFFF_FFFF;
    train(32'h40, BR, 1, 32'h100);
    for (int n = 0; n < 4; n++) look(32'h40, BR, 1, 1, 32'h100, "saturate");
    for (int n = 0; n < 40; n++)
      step(0, 0, rand_pc(), rand_op(), 1'($urandom_range(0, 1)), rand_pc(), rand_op(),
           1'($urandom_range(0, 1)), $urandom, 0, 0, 0, "saturate_rand");

    repeat (2) @(negedge clk);
    check("end", "queue_drained", queue_exp.size(), 0);
    stim_done = 1;
  end

  initial begin : finisher
    fork
      wait (stim_done);
      begin
        #200000;
        check("timeout", "stim_done", 0, 1);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
